icb_sram_slave: RTL and testbench

ICB slave endpoint that sits directly downstream of one slave port of the 2-master/8-slave ICB bus and turns ICB commands into accesses on a single-port synchronous SRAM with 1-cycle read latency. It returns read data on the ICB response channel and holds it under response back-pressure without losing data. It sustains one read per cycle when the master is always ready. Writes are fire-and-forget and produce no response, because the bus routes only read responses.

---
 rtl/icb_sram_slave_pkg.sv | 18 +
 rtl/icb_rsp_hold.sv | 38 +++
 rtl/icb_sram_slave.sv | 104 ++++++++++
 tb/tb_icb_sram_slave.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icb_sram_slave_pkg
// Description : Shared widths and FSM state encoding for the ICB SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
package icb_sram_slave_pkg;

    localparam int c_icb_aw = 32;
    localparam int c_icb_dw = 32;
    localparam int c_icb_mw = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LIVE = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/icb_rsp_hold.sv
`default_nettype none
// ============================================================================
// Module      : icb_rsp_hold
// Description : Response hold register and LIVE/HELD response data mux.
// Revision    : 1.0 - initial release
// ============================================================================
module icb_rsp_hold
    import icb_sram_slave_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                capture,
    input  logic                sel_live,
    input  logic [c_icb_dw-1:0] live_rdata,
    input  logic                live_err,
    output logic [c_icb_dw-1:0] rsp_rdata,
    output logic                rsp_err
);

    logic [c_icb_dw-1:0] r_hold_rdata;
    logic                r_hold_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_rdata <= '0;
            r_hold_err   <= 1'b0;
        end else if (capture) begin
            r_hold_rdata <= live_rdata;
            r_hold_err   <= live_err;
        end
    end

    // Outside LIVE the hold register drives the bus, which reads 0 after reset.
    assign rsp_rdata = sel_live ? live_rdata : r_hold_rdata;
    assign rsp_err   = sel_live ? live_err   : r_hold_err;

endmodule
`default_nettype wire

// File: rtl/icb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : icb_sram_slave
// Description : ICB slave to 1-cycle-latency single-port SRAM bridge.
//               Define ICB_SRAM_ADDR_CHECK_EN to flag out-of-range accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module icb_sram_slave
    import icb_sram_slave_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                icb_cmd_valid,
    output logic                icb_cmd_ready,
    input  logic [c_icb_aw-1:0] icb_cmd_addr,
    input  logic                icb_cmd_read,
    input  logic [c_icb_dw-1:0] icb_cmd_wdata,
    input  logic [c_icb_mw-1:0] icb_cmd_wmask,
    output logic                icb_rsp_valid,
    input  logic                icb_rsp_ready,
    output logic                icb_rsp_err,
    output logic [c_icb_dw-1:0] icb_rsp_rdata,
    output logic                sram_en,
    output logic [c_icb_mw-1:0] sram_we,
    output logic [AW-1:0]       sram_addr,
    output logic [c_icb_dw-1:0] sram_wdata,
    input  logic [c_icb_dw-1:0] sram_rdata
);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_err;
    logic                w_acc;
    logic                w_rd_acc;
    logic                w_oor;
    logic                w_unused_addr;
    logic [c_icb_dw-1:0] w_live_rdata;

    assign icb_rsp_valid = (r_state != ST_IDLE);
    assign icb_cmd_ready = (r_state == ST_IDLE) | (icb_rsp_valid & icb_rsp_ready);
    assign w_acc         = icb_cmd_valid & icb_cmd_ready;
    assign w_rd_acc      = w_acc & icb_cmd_read;
    assign w_unused_addr = ^{icb_cmd_addr[c_icb_aw-1:AW+2], icb_cmd_addr[1:0]};

`ifdef ICB_SRAM_ADDR_CHECK_EN
    if (AW >= 27) begin : g_no_oor
        assign w_oor = 1'b0;
    end else begin : g_oor
        assign w_oor = |icb_cmd_addr[28:AW+2];
    end
`else
    assign w_oor = 1'b0;
`endif

    assign sram_en    = w_acc & ~w_oor;
    assign sram_we    = (sram_en & ~icb_cmd_read) ? icb_cmd_wmask : '0;
    assign sram_addr  = icb_cmd_addr[AW+1:2];
    assign sram_wdata = icb_cmd_wdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_rd_acc ? ST_LIVE : ST_IDLE;
            ST_LIVE, ST_HELD: begin
                if (icb_rsp_ready) begin
                    w_state_nxt = w_rd_acc ? ST_LIVE : ST_IDLE;
                end else begin
                    w_state_nxt = ST_HELD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_acc) begin
                r_err <= w_oor;
            end
        end
    end

    // An out-of-range read never touched the SRAM, so its data is forced to 0.
    assign w_live_rdata = r_err ? '0 : sram_rdata;

    icb_rsp_hold u_rsp_hold (
        .clk        (clk),
        .rst        (rst),
        .capture    ((r_state == ST_LIVE) & ~icb_rsp_ready),
        .sel_live   (r_state == ST_LIVE),
        .live_rdata (w_live_rdata),
        .live_err   (r_err),
        .rsp_rdata  (icb_rsp_rdata),
        .rsp_err    (icb_rsp_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_icb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_icb_sram_slave
// Description : Directed self-checking bench for icb_sram_slave with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icb_sram_slave;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [0:4095];
    logic [31:0] mem_q;
    logic        ovr;
    logic [31:0] ovr_val;
    int          vecs;
    int          errs;

    icb_sram_slave #(.AW(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .icb_cmd_valid (cmd_valid),
        .icb_cmd_ready (cmd_ready),
        .icb_cmd_addr  (cmd_addr),
        .icb_cmd_read  (cmd_read),
        .icb_cmd_wdata (cmd_wdata),
        .icb_cmd_wmask (cmd_wmask),
        .icb_rsp_valid (rsp_valid),
        .icb_rsp_ready (rsp_ready),
        .icb_rsp_err   (rsp_err),
        .icb_rsp_rdata (rsp_rdata),
        .sram_en       (sram_en),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0) begin
                mem_q <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end
    assign sram_rdata = ovr ? ovr_val : mem_q;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m);
        cmd_valid = v;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = m;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rsp_ready = 1'b1;
        step;
        step;
        #1;
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vecs++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        vecs++; if (rsp_rdata !== 32'h0) begin errs++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        vecs++; if (sram_en !== 1'b0) begin errs++; $display("FAIL reset_sram_en got %b want 0", sram_en); end
        vecs++; if (sram_we !== 4'h0) begin errs++; $display("FAIL reset_sram_we got %h want 0", sram_we); end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        step;
        cmd(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        #1;
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL wr_cmd_ready got %b want 1", cmd_ready); end
        vecs++; if (sram_en !== 1'b1) begin errs++; $display("FAIL wr_sram_en got %b want 1", sram_en); end
        vecs++; if (sram_we !== 4'hF) begin errs++; $display("FAIL wr_sram_we got %h want f", sram_we); end
        vecs++; if (sram_addr !== 12'h004) begin errs++; $display("FAIL wr_sram_addr got %h want 004", sram_addr); end
        vecs++; if (sram_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_sram_wdata got %h want deadbeef", sram_wdata); end
        step;
        cmd(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        #1;
        vecs++; if (sram_en !== 1'b1 || sram_we !== 4'h0) begin errs++; $display("FAIL rd_sram_drive got en=%b we=%h want en=1 we=0", sram_en, sram_we); end
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL wr_no_rsp got %b want 0", rsp_valid); end
        step;
        cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        vecs++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL rd_rsp_valid got %b want 1", rsp_valid); end
        vecs++; if (rsp_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_rsp_rdata got %h want deadbeef", rsp_rdata); end
        vecs++; if (rsp_err !== 1'b0) begin errs++; $display("FAIL rd_rsp_err got %b want 0", rsp_err); end
        step;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rd_retire got %b want 0", rsp_valid); end
    endtask

    task automatic test_partial_write;
        cmd(1'b1, 1'b0, 32'h10, 32'h000000AA, 4'h1);
        step;
        cmd(1'b1, 1'b0, 32'h10, 32'h11223344, 4'h0);
        #1;
        vecs++; if (sram_en !== 1'b1 || sram_we !== 4'h0) begin errs++; $display("FAIL mask0_drive got en=%b we=%h want en=1 we=0", sram_en, sram_we); end
        step;
        cmd(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        step;
        cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEAA) begin errs++; $display("FAIL partial_rdata got v=%b %h want v=1 deadbeaa", rsp_valid, rsp_rdata); end
        step;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            cmd(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA5000000 + 32'(i), 4'hF);
            #1;
            vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_wr_ready[%0d] got %b want 1", i, cmd_ready); end
            step;
        end
        rsp_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) cmd(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h0, 4'h0);
            else        cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            if (i < 10) begin
                vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_rd_ready[%0d] got %b want 1", i, cmd_ready); end
            end
            if (i > 0) begin
                vecs++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000000 + 32'(i - 1)) begin
                    errs++; $display("FAIL b2b_rsp[%0d] got v=%b %h want v=1 %h", i - 1, rsp_valid, rsp_rdata, 32'hA5000000 + 32'(i - 1));
                end
            end
            step;
        end
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure;
        cmd(1'b1, 1'b1, 32'h100, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        #1;
        vecs++; if (sram_en !== 1'b1) begin errs++; $display("FAIL bp_accept got %b want 1", sram_en); end
        step;
        cmd(1'b1, 1'b1, 32'h104, 32'h0, 4'h0);
        #1;
        vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000000) begin errs++; $display("FAIL bp_live got v=%b %h want v=1 a5000000", rsp_valid, rsp_rdata); end
        vecs++; if (cmd_ready !== 1'b0 || sram_en !== 1'b0) begin errs++; $display("FAIL bp_stall got rdy=%b en=%b want 0 0", cmd_ready, sram_en); end
        for (int k = 0; k < 2; k++) begin
            step;
            ovr = 1'b1;
            ovr_val = 32'h12345678 + 32'(k);
            #1;
            vecs++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000000 || cmd_ready !== 1'b0) begin
                errs++; $display("FAIL bp_held[%0d] got v=%b %h rdy=%b want v=1 a5000000 rdy=0", k, rsp_valid, rsp_rdata, cmd_ready);
            end
        end
        step;
        rsp_ready = 1'b1;
        ovr = 1'b0;
        #1;
        vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000000) begin errs++; $display("FAIL bp_release got v=%b %h want v=1 a5000000", rsp_valid, rsp_rdata); end
        vecs++; if (cmd_ready !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 12'h041) begin errs++; $display("FAIL bp_reaccept got rdy=%b en=%b a=%h want 1 1 041", cmd_ready, sram_en, sram_addr); end
        step;
        cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000001) begin errs++; $display("FAIL bp_next got v=%b %h want v=1 a5000001", rsp_valid, rsp_rdata); end
        step;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_out_of_range;
        cmd(1'b1, 1'b0, 32'h0, 32'h0BADF00D, 4'hF);
        step;
        cmd(1'b1, 1'b1, 32'h0001_0000, 32'h0, 4'h0);
        #1;
`ifdef ICB_SRAM_ADDR_CHECK_EN
        vecs++; if (sram_en !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL oor_accept got en=%b rdy=%b want 0 1", sram_en, cmd_ready); end
`else
        vecs++; if (sram_en !== 1'b1 || sram_addr !== 12'h000) begin errs++; $display("FAIL alias_accept got en=%b a=%h want 1 000", sram_en, sram_addr); end
`endif
        step;
        cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
`ifdef ICB_SRAM_ADDR_CHECK_EN
        vecs++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL oor_rsp got v=%b e=%b %h want 1 1 0", rsp_valid, rsp_err, rsp_rdata); end
`else
        vecs++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BADF00D) begin errs++; $display("FAIL alias_rsp got v=%b e=%b %h want 1 0 0badf00d", rsp_valid, rsp_err, rsp_rdata); end
`endif
        step;
    endtask

    task automatic test_reset_held;
        cmd(1'b1, 1'b1, 32'h108, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        step;
        cmd(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step;
        vecs++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5000002) begin errs++; $display("FAIL rh_held got v=%b %h want v=1 a5000002", rsp_valid, rsp_rdata); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        vecs++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL rh_after got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready); end
        vecs++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errs++; $display("FAIL rh_cleared got %h e=%b want 0 0", rsp_rdata, rsp_err); end
        for (int k = 0; k < 3; k++) begin
            step;
            vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rh_stale[%0d] got %b want 0", k, rsp_valid); end
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        ovr = 1'b0;
        ovr_val = 32'h0;
        test_reset;
        test_write_read;
        test_partial_write;
        test_back_to_back;
        test_backpressure;
        test_out_of_range;
        test_reset_held;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
